// File: rtl/linalg_pkg.sv
// Shared widths, scheduler state encoding and identity-matrix helper for the
// fixed-point point-transform datapath.
package linalg_pkg;

  localparam int WII_DEF = 9;
  localparam int WIF_DEF = 16;
  localparam int WOI_DEF = 9;
  localparam int WOF_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Element (row, col) of the identity matrix with frac_w fraction bits.
  function automatic logic [63:0] ident_elem(input int row, input int col, input int frac_w);
    return (row == col) ? (64'd1 << frac_w) : 64'd0;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Single multiply-accumulate step: one truncating, saturating multiplier feeding
// one saturating adder with a registered accumulator.
module fxp_mac #(
  parameter int WII = 9,
  parameter int WIF = 16,
  parameter int WOI = 9,
  parameter int WOF = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WII+WIF-1:0]   a,
  input  logic [WII+WIF-1:0]   b,
  output logic [WOI+WOF-1:0]   sum,
  output logic                 ovf
);

  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  localparam int WP = 2 * WI;
  localparam int WW = WP + WO + 2;
  localparam int PL = (WOF > 2 * WIF) ? (WOF - 2 * WIF) : 0;
  localparam int PR = (2 * WIF > WOF) ? (2 * WIF - WOF) : 0;
  localparam logic [WO-1:0] MAXV = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINV = {1'b1, {(WO-1){1'b0}}};

  // Returns {overflow, value} with value clipped to the output range.
  function automatic logic [WO:0] sat_ww(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] hi;
    logic                 o;
    hi = v >>> (WO - 1);
    o  = (hi != '0) && (hi != '1);
    return {o, o ? (v[WW-1] ? MINV : MAXV) : v[WO-1:0]};
  endfunction

  // Full-precision product, truncated (floor) to the output fraction width.
  function automatic logic [WO:0] fxp_mul(input logic [WI-1:0] x, input logic [WI-1:0] y);
    logic signed [WP-1:0] xe, ye, prod;
    logic signed [WW-1:0] v;
    xe   = {{WI{x[WI-1]}}, x};
    ye   = {{WI{y[WI-1]}}, y};
    prod = xe * ye;
    v    = {{(WW-WP){prod[WP-1]}}, prod};
    v    = (v <<< PL) >>> PR;
    return sat_ww(v);
  endfunction

  function automatic logic [WO:0] fxp_add(input logic [WO-1:0] x, input logic [WO-1:0] y);
    logic signed [WW-1:0] v;
    v = $signed({{(WW-WO){x[WO-1]}}, x}) + $signed({{(WW-WO){y[WO-1]}}, y});
    return sat_ww(v);
  endfunction

  logic [WO-1:0] acc_q, acc_d;
  logic [WO:0]   mul_r, add_r;

  always_comb begin
    mul_r = fxp_mul(a, b);
    add_r = fxp_add(acc_q, mul_r[WO-1:0]);
    sum   = add_r[WO-1:0];
    ovf   = mul_r[WO] | add_r[WO];
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/xform_sched.sv
// Sequential 4x4 point transform Pp[i] = sum_j H[j][i]*p[j] on one shared MAC.
// Define AFFINE_SKIP_EN to pass p[3] straight through as Pp[3] (12 MAC cycles).
module xform_sched
  import linalg_pkg::*;
#(
  parameter int WII = WII_DEF,
  parameter int WIF = WIF_DEF,
  parameter int WOI = WOI_DEF,
  parameter int WOF = WOF_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     h_we,
  input  logic [1:0]               h_row,
  input  logic [1:0]               h_col,
  input  logic [WII+WIF-1:0]       h_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0][WII+WIF-1:0]  in_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0][WOI+WOF-1:0]  out_Pp,
  output logic                     ovf,
  output logic                     busy
);

  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
`ifdef AFFINE_SKIP_EN
  localparam logic [1:0] LAST_I = 2'd2;
  localparam int WR = WI + WO + 2;
  localparam int RL = (WOF > WIF) ? (WOF - WIF) : 0;
  localparam int RR = (WIF > WOF) ? (WIF - WOF) : 0;
  localparam logic [WO-1:0] MAXV = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINV = {1'b1, {(WO-1){1'b0}}};

  // Requantise an input-format value to the output format, {overflow, value}.
  function automatic logic [WO:0] resize_sat(input logic [WI-1:0] x);
    logic signed [WR-1:0] v, hi;
    logic                 o;
    v  = {{(WR-WI){x[WI-1]}}, x};
    v  = (v <<< RL) >>> RR;
    hi = v >>> (WO - 1);
    o  = (hi != '0) && (hi != '1);
    return {o, o ? (v[WR-1] ? MINV : MAXV) : v[WO-1:0]};
  endfunction
`else
  localparam logic [1:0] LAST_I = 2'd3;
`endif

  state_e              state_q, state_d;
  logic [1:0]          i_q, i_d, j_q, j_d;
  logic [WI-1:0]       h_q [4][4];
  logic [WI-1:0]       h_d [4][4];
  logic [3:0][WI-1:0]  p_q, p_d;
  logic [3:0][WO-1:0]  pp_q, pp_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic                accept, mac_en, mac_clr, mac_ovf;
  logic [WO-1:0]       mac_sum;
  logic [WI-1:0]       mac_a, mac_b;

  // in_ready is held low while reset is asserted even though the flop already reads IDLE.
  assign in_ready  = in_ready_q & ~reset;
  assign out_valid = out_valid_q;
  assign out_Pp    = pp_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

  assign accept  = in_valid & in_ready;
  assign mac_a   = h_q[j_q][i_q];
  assign mac_b   = p_q[j_q];
  assign mac_en  = (state_q == MAC);
  assign mac_clr = accept | (mac_en & (j_q == 2'd3));

  fxp_mac #(
    .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .clr   (mac_clr),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

`ifdef AFFINE_SKIP_EN
  logic [WO:0] p3_rs;
  assign p3_rs = resize_sat(p_q[3]);
`endif

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    h_d         = h_q;
    p_d         = p_q;
    pp_d        = pp_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (h_we) h_d[h_row][h_col] = h_data;
        if (accept) begin
          p_d        = in_p;
          ovf_d      = 1'b0;
          i_d        = 2'd0;
          j_d        = 2'd0;
          state_d    = MAC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MAC: begin
        ovf_d = ovf_q | mac_ovf;
        j_d   = j_q + 2'd1;
        if (j_q == 2'd3) begin
          pp_d[i_q] = mac_sum;
          i_d       = i_q + 2'd1;
          if (i_q == LAST_I) begin
            i_d         = 2'd0;
            state_d     = DONE;
            out_valid_d = 1'b1;
`ifdef AFFINE_SKIP_EN
            pp_d[3] = p3_rs[WO-1:0];
            ovf_d   = ovf_q | mac_ovf | p3_rs[WO];
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= 2'd0;
      j_q         <= 2'd0;
      pp_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          h_q[r][c] <= WI'(ident_elem(r, c, WIF));
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      pp_q        <= pp_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      h_q         <= h_d;
    end
  end

endmodule

// File: tb/tb_xform_sched.sv
// Randomised bench for xform_sched against a plain-arithmetic matrix model.
// Honours AFFINE_SKIP_EN when the design is built with it.
module tb_xform_sched;

  localparam int WI = 25;
  localparam int WO = 25;
  localparam longint ONE  = 64'sd65536;
  localparam longint OMAX = (64'sd1 <<< 24) - 1;
  localparam longint OMIN = -(64'sd1 <<< 24);
`ifdef AFFINE_SKIP_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 17;
`endif

  logic                 clk = 1'b0;
  logic                 reset, h_we, in_valid, out_ready;
  logic [1:0]           h_row, h_col;
  logic [WI-1:0]        h_data;
  logic                 in_ready, out_valid, ovf, busy;
  logic [3:0][WI-1:0]   in_p;
  logic [3:0][WO-1:0]   out_Pp;

  xform_sched dut (
    .clk(clk), .reset(reset), .h_we(h_we), .h_row(h_row), .h_col(h_col),
    .h_data(h_data), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_Pp(out_Pp),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: H as real matrix entries in Q.16, plain integer maths.
  longint hm [4][4];
  longint pv [4];
  longint m_pp [4];
  bit     m_ovf;

  function automatic longint sat(input longint v);
    if (v > OMAX) begin m_ovf = 1'b1; return OMAX; end
    if (v < OMIN) begin m_ovf = 1'b1; return OMIN; end
    return v;
  endfunction

  task automatic model_run();
    longint acc;
    m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef AFFINE_SKIP_EN
      if (i == 3) begin m_pp[3] = sat(pv[3]); continue; end
`endif
      acc = 0;
      for (int j = 0; j < 4; j++)
        acc = sat(acc + sat((hm[j][i] * pv[j]) >>> 16));
      m_pp[i] = acc;
    end
  endtask

  task automatic model_ident();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        hm[r][c] = (r == c) ? ONE : 0;
  endtask

  function automatic longint pp_got(input int i);
    logic signed [WO-1:0] s;
    s = out_Pp[i];
    return longint'(s);
  endfunction

  function automatic longint rnd_fx();
    logic signed [WI-1:0] w;
    if ($urandom_range(0, 7) == 0) begin
      w = WI'($urandom);
      return longint'(w);
    end
    return longint'($urandom_range(0, 8 * 65536)) - 4 * ONE;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic wr_h(input int r, input int c, input longint v);
    h_we = 1'b1; h_row = 2'(r); h_col = 2'(c); h_data = v[WI-1:0];
    @(negedge clk);
    h_we = 1'b0;
    hm[r][c] = v;
  endtask

  task automatic run(input string tag, input int hold, input bit wr_same,
                     input int r, input int c, input longint v);
    int lat;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) in_p[k] = pv[k][WI-1:0];
    if (wr_same) begin
      h_we = 1'b1; h_row = 2'(r); h_col = 2'(c); h_data = v[WI-1:0];
      hm[r][c] = v;
    end
    model_run();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; h_we = 1'b0;
        check({tag, "_busy"}, longint'(busy), 1);
        check({tag, "_inrdy_mac"}, longint'(in_ready), 0);
      end
    end while (!out_valid && lat < 40);
    check({tag, "_lat"}, lat, LAT);
    for (int i = 0; i < 4; i++) check($sformatf("%s_pp%0d", tag, i), pp_got(i), m_pp[i]);
    check({tag, "_ovf"}, longint'(ovf), longint'(m_ovf));
    for (int h = 0; h < hold; h++) begin
      h_we = (h == 0);
      h_row = 2'd0; h_col = 2'd0; h_data = WI'(7 * ONE);
      @(negedge clk);
      check($sformatf("%s_hold%0d_vld", tag, h), longint'(out_valid), 1);
      check($sformatf("%s_hold%0d_inrdy", tag, h), longint'(in_ready), 0);
      check($sformatf("%s_hold%0d_pp0", tag, h), pp_got(0), m_pp[0]);
    end
    h_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_exit_vld"}, longint'(out_valid), 0);
    check({tag, "_exit_inrdy"}, longint'(in_ready), 1);
    check({tag, "_exit_busy"}, longint'(busy), 0);
    check({tag, "_exit_pp1"}, pp_got(1), m_pp[1]);
  endtask

  initial begin
    int seen, nw;
    reset = 1'b1; h_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    h_row = 2'd0; h_col = 2'd0; h_data = '0; in_p = '0;
    model_ident();
    repeat (3) @(negedge clk);
    check("rst_inrdy_low", longint'(in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_inrdy", longint'(in_ready), 1);
    check("rst_vld", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ovf", longint'(ovf), 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_pp%0d", i), pp_got(i), 0);

    pv = '{ONE, 2 * ONE, 3 * ONE, ONE};
    run("ident", 0, 1'b0, 0, 0, 0);

    wr_h(3, 0, 5 * ONE);
    wr_h(3, 1, -2 * ONE);
    pv = '{ONE, ONE, 0, ONE};
    run("affine", 0, 1'b0, 0, 0, 0);
    check("affine_pp0_const", pp_got(0), 6 * ONE);
    check("affine_pp1_const", pp_got(1), -ONE);

    wr_h(0, 0, 200 * ONE);
    pv = '{200 * ONE, 0, 0, ONE};
    run("sat", 0, 1'b0, 0, 0, 0);
    check("sat_pp0_max", pp_got(0), OMAX);
    check("sat_ovf_const", longint'(ovf), 1);

    wr_h(0, 0, ONE);
    pv = '{ONE, 0, 0, ONE};
    run("hold", 5, 1'b0, 0, 0, 0);
    pv = '{2 * ONE, 0, 0, 0};
    run("after_hold", 0, 1'b0, 0, 0, 0);

    pv = '{0, ONE, 0, 0};
    run("same_cyc_wr", 0, 1'b1, 1, 2, 3 * ONE);

    // Abort a transform part-way through MAC.
    pv = '{ONE, ONE, ONE, ONE};
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) in_p[k] = pv[k][WI-1:0];
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_inrdy_low", longint'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("abort_inrdy", longint'(in_ready), 1);
    model_ident();
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_vld", seen, 0);
    check("abort_busy", longint'(busy), 0);
    pv = '{ONE, 2 * ONE, -3 * ONE, ONE};
    run("post_abort", 0, 1'b0, 0, 0, 0);

    for (int t = 0; t < 12; t++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr_h($urandom_range(0, 3), $urandom_range(0, 3), rnd_fx());
      for (int k = 0; k < 4; k++) pv[k] = rnd_fx();
      run($sformatf("rnd%0d", t), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3), rnd_fx());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xform_sched.md
XFORM_SCHED -- requirements
Module: xform_sched

Interface
REQ-001 The block SHALL have parameter WII, default 9, input integer width.
REQ-002 The block SHALL have parameter WIF, default 16, input fraction width.
REQ-003 The block SHALL have parameter WOI, default 9, output integer width.
REQ-004 The block SHALL have parameter WOF, default 16, output fraction width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have the matrix write ports:
- h_we  in  1  matrix element write strobe.
- h_row  in  2  matrix first index j.
- h_col  in  2  matrix second index i.
- h_data  in  WII+WIF  signed element value.
REQ-007 The block SHALL have the input point ports:
- in_valid  in  1  point offered.
- in_ready  out  1  point accepted when both high.
- in_p  in  [3:0][WII+WIF-1:0]  signed point p.
REQ-008 The block SHALL have the output ports:
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when both high.
- out_Pp  out  [3:0][WOI+WOF-1:0]  signed result p'.
- ovf  out  1  any multiply or add overflow during this result.
- busy  out  1  high outside IDLE.

Function
REQ-009 The block SHALL compute Pp[i] = sum over j=0..3 of H[j][i]*p[j], using one shared multiplier and one shared adder.
REQ-010 Arithmetic SHALL be fixed-point with truncation (ROUND=0) and saturation on overflow; each overflow event SHALL be ORed into ovf.
REQ-011 The FSM SHALL have the states IDLE, MAC and DONE; reset SHALL enter IDLE.
REQ-012 In IDLE, in_ready SHALL be 1 and all other handshakes 0; in_valid&&in_ready SHALL capture in_p, clear the accumulator and ovf, set i=j=0 and go to MAC.
REQ-013 MAC SHALL take one term per cycle with j inner and i outer, over 16 cycles. At j=3 the saturated sum SHALL be written to out_Pp[i] and the accumulator cleared. After i=3,j=3 the FSM SHALL go to DONE.
REQ-014 DONE SHALL hold out_valid=1 with out_Pp and ovf stable until out_ready=1, then return to IDLE; the accept cycle is cycle 0 and out_valid first rises at cycle 17.
REQ-015 in_ready SHALL be 0 in MAC and DONE; there is no overlap between transforms.
REQ-016 h_we SHALL write H[h_row][h_col] only in IDLE; h_we in MAC or DONE SHALL be ignored with no side effect.
REQ-017 When h_we and an input accept occur in the same IDLE cycle, the write SHALL commit first and the transform SHALL use the updated element.
REQ-018 out_Pp and ovf SHALL keep their last values after the DONE exit until the next result is written.

Reset
REQ-019 Reset SHALL set out_valid=0, in_ready=0 during reset then 1 in IDLE, busy=0, ovf=0, out_Pp=0, accumulator=0, i=j=0.
REQ-020 Reset SHALL load H with identity: diagonal 1.0 (1<<WIF), all other elements 0.
REQ-021 Reset asserted during MAC or DONE SHALL abort the transform with no out_valid pulse.

Configuration
REQ-022 When AFFINE_SKIP_EN is defined, i=3 SHALL be skipped: Pp[3]=p[3] resized to WOI/WOF, MAC SHALL take 12 cycles and out_valid SHALL rise at cycle 13.
REQ-023 When AFFINE_SKIP_EN is undefined, all 16 terms SHALL be computed as in REQ-013.

Structure
REQ-024 Package linalg_pkg SHALL hold default widths, the FSM state enum (IDLE, MAC, DONE) and the identity-matrix constant function.
REQ-025 One sub-module fxp_mac SHALL wrap a single fxp_mul and fxp_add with a registered accumulator, clear input and overflow output; xform_sched SHALL hold the FSM, the H register file and the index counters.

Verification
REQ-026 Post-reset identity H, p=(1.0,2.0,3.0,1.0) -> out_valid at cycle 17, Pp=(1.0,2.0,3.0,1.0), ovf=0.
REQ-027 Write H[3][0]=5.0 and H[3][1]=-2.0 in IDLE, p=(1.0,1.0,0,1.0) -> Pp=(6.0,-1.0,0,1.0).
REQ-028 H[0][0]=200.0, p[0]=200.0 -> ovf=1 and Pp[0] saturated to the most positive output value.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_valid and Pp stable, in_ready=0; h_we to H[0][0] in that window -> H unchanged on the next transform.
REQ-030 Reset at MAC cycle 8 -> no out_valid pulse, in_ready=1 the cycle after reset deasserts, H returns to identity.
REQ-031 With AFFINE_SKIP_EN defined and p[3]=1.0 -> out_valid at cycle 13 and Pp[3]=1.0 regardless of column-3 contents of H.
